// File: rtl/sgdma_rd_pkg.sv
// Shared types and constants for the scatter-gather DMA read engine.
package sgdma_rd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam int unsigned PAGE_BYTES     = 4096;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] len;
    } cmd_t;

endpackage

// File: rtl/sgdma_rd_burst_calc.sv
// Burst length for the next AR: min(MAX_BURST, remaining beats, beats left in the 4KB page).
module sgdma_rd_burst_calc
    import sgdma_rd_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int BYTES     = 4
) (
    input  logic [11:0] addr_lo,
    input  logic [15:0] rem,
    output logic [4:0]  bl
);

    localparam int SZ = $clog2(BYTES);

    logic [12:0] page_bytes;
    logic [12:0] page_beats;
    logic [15:0] lim;

    always_comb begin
        page_bytes = 13'(PAGE_BYTES) - {1'b0, addr_lo};
        page_beats = page_bytes >> SZ;
        lim        = rem;
        if ({3'b000, page_beats} < lim)
            lim = {3'b000, page_beats};
        if (16'(MAX_BURST) < lim)
            lim = 16'(MAX_BURST);
        bl = lim[4:0];
    end

endmodule

// File: rtl/sgdma_rd_engine.sv
// Scatter-gather DMA read engine: splits one {addr,len} command into AXI3 INCR bursts.
// Optional sticky response-error handling is enabled with `define SGDMA_RD_ERR_EN.
module sgdma_rd_engine
    import sgdma_rd_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MAX_BURST  = 16,
    parameter int MAX_OUTST  = 2,
    parameter int FIFO_DEPTH = 64,
    parameter int ARID       = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [3:0]                    arid_o,
    output logic [31:0]                   araddr_o,
    output logic [3:0]                    arlen_o,
    output logic [2:0]                    arsize_o,
    output logic [1:0]                    arburst_o,
    output logic                          arvalid_o,
    input  logic                          arready_i,
    input  logic [3:0]                    rid_i,
    input  logic [DATA_W-1:0]             rdata_i,
    input  logic [1:0]                    rresp_i,
    input  logic                          rlast_i,
    input  logic                          rvalid_i,
    output logic                          rready_o,
    input  logic                          start_i,
    input  logic                          desc_done_i,
    input  logic [47:0]                   cmd_i,
    output logic                          done_o,
    output logic                          err_o,
    input  logic                          fifo_afull_i,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_free_i,
    output logic                          fifo_wren_o,
    output logic [DATA_W-1:0]             fifo_wdata_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int RW    = $clog2(FIFO_DEPTH) + 2;

    state_e        state_q, state_d;
    logic [31:0]   addr_q;
    logic [15:0]   rem_q;
    logic [RW-1:0] resv_q, resv_d;
    logic [2:0]    outst_q, outst_d;
    logic          arvalid_q;
    logic          err_q;

    cmd_t          cmd;
    logic [15:0]   beats;
    logic [4:0]    bl;
    logic [4:0]    bl_m1;
    logic          ar_hs, r_acc, r_err, stop, credit_ok, ar_set, cmd_go;
    logic          unused_ok;

    assign cmd    = cmd_t'(cmd_i);
    assign beats  = cmd.len >> SZ;
    assign cmd_go = (state_q == S_IDLE) && start_i;

    sgdma_rd_burst_calc #(
        .MAX_BURST (MAX_BURST),
        .BYTES     (BYTES)
    ) u_burst_calc (
        .addr_lo (addr_q[11:0]),
        .rem     (rem_q),
        .bl      (bl)
    );

    assign ar_hs    = arvalid_q && arready_i;
    assign rready_o = (state_q != S_IDLE) && !fifo_afull_i;
    // Beats arriving with nothing outstanding are protocol errors and are dropped.
    assign r_acc    = rvalid_i && rready_o && (outst_q != 3'd0);

`ifdef SGDMA_RD_ERR_EN
    assign r_err = r_acc && (rresp_i != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (cmd_go)
            err_q <= 1'b0;
        else if (r_err)
            err_q <= 1'b1;
    end
`else
    assign r_err = 1'b0;
    assign err_q = 1'b0;
`endif

    assign stop      = err_q || r_err;
    assign credit_ok = desc_done_i || (17'(fifo_free_i) >= 17'(resv_q) + 17'(bl));
    assign ar_set    = (state_q == S_ISSUE) && !arvalid_q && (rem_q != 16'd0) && !stop &&
                       (outst_q < 3'(MAX_OUTST)) && credit_ok;

    always_comb begin
        outst_d = outst_q;
        if (ar_hs && !(r_acc && rlast_i))
            outst_d = outst_q + 3'd1;
        else if (!ar_hs && r_acc && rlast_i)
            outst_d = outst_q - 3'd1;

        resv_d = resv_q;
        if (ar_hs)
            resv_d = resv_d + RW'(bl);
        if (r_acc && (resv_q != '0))
            resv_d = resv_d - RW'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i && (beats != 16'd0)) state_d = S_ISSUE;
            S_ISSUE: begin
                if (ar_hs) begin
                    if ((rem_q == 16'(bl)) || stop) state_d = S_DRAIN;
                end else if (!arvalid_q && ((rem_q == 16'd0) || stop)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (outst_d == 3'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= 32'd0;
            rem_q     <= 16'd0;
            resv_q    <= '0;
            outst_q   <= 3'd0;
            arvalid_q <= 1'b0;
        end else begin
            outst_q <= outst_d;
            if (cmd_go) begin
                addr_q <= cmd.addr & ~32'(BYTES - 1);
                rem_q  <= beats;
                resv_q <= '0;
            end else begin
                resv_q <= resv_d;
                if (ar_hs) begin
                    addr_q <= addr_q + (32'(bl) << SZ);
                    rem_q  <= rem_q - 16'(bl);
                end
            end
            // Once raised, arvalid and its payload (addr_q/rem_q) hold until the handshake.
            if (ar_hs)
                arvalid_q <= 1'b0;
            else if (ar_set)
                arvalid_q <= 1'b1;
        end
    end

    assign bl_m1        = bl - 5'd1;
    assign arid_o       = 4'(ARID);
    assign araddr_o     = addr_q;
    assign arlen_o      = bl_m1[3:0];
    assign arsize_o     = 3'(SZ);
    assign arburst_o    = AXI_BURST_INCR;
    assign arvalid_o    = arvalid_q;
    assign done_o       = (state_q == S_IDLE);
    assign err_o        = err_q;
    assign fifo_wren_o  = r_acc && !r_err;
    assign fifo_wdata_o = rdata_i;
    assign unused_ok    = ^{rid_i, rresp_i, bl_m1[4]};

endmodule

// File: tb/tb_sgdma_rd_engine.sv
// Directed bench for sgdma_rd_engine (DATA_W=32, MAX_BURST=16, MAX_OUTST=2) with an AXI read slave model.
module tb_sgdma_rd_engine;

    logic        clk, rst_n;
    logic [3:0]  arid_o, arlen_o;
    logic [31:0] araddr_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic        arvalid_o, arready_i;
    logic [3:0]  rid_i;
    logic [31:0] rdata_i, fifo_wdata_o;
    logic [1:0]  rresp_i;
    logic        rlast_i, rvalid_i, rready_o;
    logic        start_i, desc_done_i, done_o, err_o;
    logic [47:0] cmd_i;
    logic        fifo_afull_i, fifo_wren_o;
    logic [6:0]  fifo_free_i;

    sgdma_rd_engine dut (
        .clk(clk), .rst_n(rst_n), .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
        .arsize_o(arsize_o), .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
        .rready_o(rready_o), .start_i(start_i), .desc_done_i(desc_done_i), .cmd_i(cmd_i),
        .done_o(done_o), .err_o(err_o), .fifo_afull_i(fifo_afull_i), .fifo_free_i(fifo_free_i),
        .fifo_wren_o(fifo_wren_o), .fifo_wdata_o(fifo_wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic        ar_ready_en, r_en;
    logic [31:0] ar_addr_log[$];
    logic [3:0]  ar_len_log[$];
    int          pend_q[$];
    int          beat_in_burst, gbeat, err_at, wren_cnt, rlast_cnt, rlast_at_ar3;

    assign arready_i = ar_ready_en;
    assign rid_i     = 4'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // AXI read slave: samples handshakes mid-cycle, updates drives just after the rising edge.
    initial begin
        logic        ar_hs, r_hs;
        logic [31:0] cap_a;
        logic [3:0]  cap_l;
        rvalid_i = 1'b0; rlast_i = 1'b0; rdata_i = 32'd0; rresp_i = 2'b00;
        forever begin
            @(negedge clk);
            ar_hs = arvalid_o && arready_i;
            r_hs  = rvalid_i && rready_o;
            cap_a = araddr_o;
            cap_l = arlen_o;
            if (fifo_wren_o) begin
                wren_cnt++;
                check("wdata", fifo_wdata_o, rdata_i);
            end
            if (r_hs && rlast_i) rlast_cnt++;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend_q.delete();
                beat_in_burst = 0;
            end else begin
                if (ar_hs) begin
                    if (ar_addr_log.size() == 2) rlast_at_ar3 = rlast_cnt;
                    ar_addr_log.push_back(cap_a);
                    ar_len_log.push_back(cap_l);
                    pend_q.push_back(int'(cap_l) + 1);
                end
                if (r_hs && pend_q.size() > 0) begin
                    gbeat++;
                    beat_in_burst++;
                    if (beat_in_burst == pend_q[0]) begin
                        void'(pend_q.pop_front());
                        beat_in_burst = 0;
                    end
                end
            end
            if (rst_n && r_en && pend_q.size() > 0) begin
                rvalid_i = 1'b1;
                rlast_i  = (beat_in_burst == pend_q[0] - 1);
                rdata_i  = 32'hA500_0000 + 32'(gbeat);
                rresp_i  = (gbeat == err_at) ? 2'b10 : 2'b00;
            end else begin
                rvalid_i = 1'b0;
                rlast_i  = 1'b0;
                rresp_i  = 2'b00;
            end
        end
    end

    task automatic clear_log();
        ar_addr_log.delete();
        ar_len_log.delete();
        gbeat = 0; wren_cnt = 0; rlast_cnt = 0; rlast_at_ar3 = -1; err_at = -1;
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic [15:0] l);
        cmd_i   = {a, l};
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (!(done_o && pend_q.size() == 0) && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_reached", {31'd0, done_o && (pend_q.size() == 0)}, 32'd1);
    endtask

    task automatic check_ar_log();
        for (int i = 0; i < ar_addr_log.size(); i++) begin
            check("no_4k_cross", {31'd0, (32'(ar_addr_log[i][11:0]) + (32'(ar_len_log[i]) + 1) * 4) <= 32'd4096}, 32'd1);
            if (i > 0)
                check("contig_addr", ar_addr_log[i], ar_addr_log[i-1] + (32'(ar_len_log[i-1]) + 1) * 4);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        int          ars;
        int          beats;
        logic [31:0] a0;
        logic [3:0]  l0;
        logic [31:0] al;
        logic [3:0]  ll;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] cap_a;
        logic [3:0]  cap_l;
        int          n;

        vecs[0] = '{32'h0000_1000, 16'd256, 4, 64, 32'h0000_1000, 4'd15, 32'h0000_10C0, 4'd15};
        vecs[1] = '{32'h0000_0FF0, 16'd64,  2, 16, 32'h0000_0FF0, 4'd3,  32'h0000_1000, 4'd11};
        vecs[2] = '{32'h0000_2000, 16'd0,   0, 0,  32'h0,         4'd0,  32'h0,         4'd0};
        vecs[3] = '{32'h0000_2000, 16'd3,   0, 0,  32'h0,         4'd0,  32'h0,         4'd0};
        vecs[4] = '{32'h0000_2003, 16'd10,  1, 2,  32'h0000_2000, 4'd1,  32'h0000_2000, 4'd1};
        vecs[5] = '{32'h0000_3FFC, 16'd40,  2, 10, 32'h0000_3FFC, 4'd0,  32'h0000_4000, 4'd8};

        rst_n = 1'b0; start_i = 1'b0; desc_done_i = 1'b0; cmd_i = 48'd0;
        fifo_afull_i = 1'b0; fifo_free_i = 7'd64; ar_ready_en = 1'b1; r_en = 1'b1;
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        check("rst_arvalid", {31'd0, arvalid_o}, 32'd0);
        check("rst_rready", {31'd0, rready_o}, 32'd0);
        check("rst_wren", {31'd0, fifo_wren_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ar_static", {arid_o, arsize_o, arburst_o}, {4'd0, 3'd2, 2'b01});

        for (int i = 0; i < 6; i++) begin
            clear_log();
            start_cmd(vecs[i].addr, vecs[i].len);
            if (vecs[i].ars == 0)
                check("zero_len_done", {31'd0, done_o}, 32'd1);
            wait_done(400);
            check("ar_count", ar_addr_log.size(), vecs[i].ars);
            check("wren_count", wren_cnt, vecs[i].beats);
            if (vecs[i].ars > 0) begin
                check("first_araddr", ar_addr_log[0], vecs[i].a0);
                check("first_arlen", {28'd0, ar_len_log[0]}, {28'd0, vecs[i].l0});
                check("last_araddr", ar_addr_log[ar_addr_log.size()-1], vecs[i].al);
                check("last_arlen", {28'd0, ar_len_log[ar_len_log.size()-1]}, {28'd0, vecs[i].ll});
            end
            check_ar_log();
        end

        // Credit stall, then AR payload held while arready is low and credit vanishes.
        clear_log();
        fifo_free_i = 7'd8;
        ar_ready_en = 1'b0;
        start_cmd(32'h0000_5000, 16'd64);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("credit_stall", {31'd0, arvalid_o}, 32'd0);
        end
        fifo_free_i = 7'd16;
        n = 0;
        while (!arvalid_o && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("credit_release", {31'd0, arvalid_o}, 32'd1);
        cap_a = araddr_o;
        cap_l = arlen_o;
        fifo_free_i = 7'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("ar_hold_valid", {31'd0, arvalid_o}, 32'd1);
            check("ar_hold_addr", araddr_o, cap_a);
            check("ar_hold_len", {28'd0, arlen_o}, {28'd0, cap_l});
        end
        ar_ready_en = 1'b1;
        fifo_free_i = 7'd64;
        wait_done(200);
        check("stall_ar_count", ar_addr_log.size(), 1);
        check("stall_araddr", cap_a, 32'h0000_5000);
        check("stall_arlen", {28'd0, cap_l}, 32'd15);
        check("stall_wren", wren_cnt, 16);

        // Last descriptor: credit waived even with zero free space.
        clear_log();
        fifo_free_i = 7'd0;
        desc_done_i = 1'b1;
        start_cmd(32'h0000_8000, 16'd128);
        wait_done(200);
        check("descdone_ar_count", ar_addr_log.size(), 2);
        check("descdone_wren", wren_cnt, 32);
        desc_done_i = 1'b0;
        fifo_free_i = 7'd64;

        // Outstanding limit with R channel stalled.
        clear_log();
        r_en = 1'b0;
        start_cmd(32'h0000_6000, 16'd256);
        repeat (20) @(posedge clk);
        #1;
        check("outst_limit", ar_addr_log.size(), 2);
        r_en = 1'b1;
        wait_done(400);
        check("outst_total_ars", ar_addr_log.size(), 4);
        check("outst_ar3_after_rlast", {31'd0, rlast_at_ar3 >= 1}, 32'd1);
        check("outst_wren", wren_cnt, 64);

        // Error response on beat 3 of the first burst.
        clear_log();
        err_at = 2;
        start_cmd(32'h0000_7000, 16'd256);
        wait_done(400);
`ifdef SGDMA_RD_ERR_EN
        check("err_sticky", {31'd0, err_o}, 32'd1);
        check("err_ar_count", ar_addr_log.size(), 2);
        check("err_wren", wren_cnt, 31);
`else
        check("noerr_flag", {31'd0, err_o}, 32'd0);
        check("noerr_ar_count", ar_addr_log.size(), 4);
        check("noerr_wren", wren_cnt, 64);
`endif
        err_at = -1;
        start_cmd(32'h0000_0000, 16'd0);
        check("err_cleared", {31'd0, err_o}, 32'd0);

        // Asynchronous reset in the middle of a transfer.
        clear_log();
        start_cmd(32'h0000_9000, 16'd256);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_arvalid", {31'd0, arvalid_o}, 32'd0);
        check("arst_rready", {31'd0, rready_o}, 32'd0);
        check("arst_wren", {31'd0, fifo_wren_o}, 32'd0);
        check("arst_done", {31'd0, done_o}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        start_cmd(32'h0000_1000, 16'd64);
        wait_done(200);
        check("post_rst_ar_count", ar_addr_log.size(), 1);
        check("post_rst_wren", wren_cnt, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
